// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator controller.
package calc_pkg;

  localparam int OPERAND_W = 12;
  localparam int SUM_W     = 14;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_ADD       = 4'hA;
  localparam logic [3:0] KEY_EQUALS    = 4'hB;
  localparam logic [3:0] KEY_CLEAR     = 4'hC;

  localparam logic [OPERAND_W-1:0] OPERAND_MAX = '1;

  typedef enum logic [2:0] {
    ST_ENT_A,
    ST_ENT_B,
    ST_REQ,
    ST_SHOW,
    ST_ERR
  } calc_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/module_calc_ctrl_if.sv
// Keypad, adder handshake and display signals of the calculator controller.
interface module_calc_ctrl_if;
  import calc_pkg::*;

  logic [3:0]           key_code;
  logic                 key_pulse;
  logic [OPERAND_W-1:0] op_a;
  logic [OPERAND_W-1:0] op_b;
  logic                 op_req;
  logic                 op_ack;
  logic [SUM_W-1:0]     sum_in;
  logic                 ovf_in;
  logic [OPERAND_W-1:0] disp_bin;
  logic                 err;
  logic                 busy;

  modport master (
    output key_code, key_pulse, op_ack, sum_in, ovf_in,
    input  op_a, op_b, op_req, disp_bin, err, busy
  );

  modport slave (
    input  key_code, key_pulse, op_ack, sum_in, ovf_in,
    output op_a, op_b, op_req, disp_bin, err, busy
  );

endinterface

// File: rtl/module_digit_acc.sv
// Decimal operand accumulator: value*10+digit with a digit-count limit,
// plus clear and parallel-load controls.
module module_digit_acc
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load,
  input  logic                 digit_en,
  input  logic [3:0]           digit,
  input  logic [OPERAND_W-1:0] load_val,
  output logic [OPERAND_W-1:0] value
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  logic [OPERAND_W-1:0] val_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [OPERAND_W-1:0] shifted;

  always_comb shifted = OPERAND_W'(val_q * OPERAND_W'(10)) + OPERAND_W'(digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      // a digit coincident with clear starts a fresh one-digit operand
      val_q <= digit_en ? OPERAND_W'(digit) : '0;
      cnt_q <= digit_en ? CNT_W'(1) : '0;
    end else if (load) begin
      val_q <= load_val;
      cnt_q <= CNT_W'(MAX_DIGITS);
    end else if (digit_en && (cnt_q < CNT_W'(MAX_DIGITS))) begin
      val_q <= shifted;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign value = val_q;

endmodule

// File: rtl/module_calc_ctrl.sv
// Keypad calculator controller: operand entry, adder handshake, result display.
// Optional ack timeout enabled by defining CALC_CTRL_TIMEOUT_EN.
module module_calc_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIGITS  = 3,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input logic                clk,
  input logic                rst_n,
  module_calc_ctrl_if.slave  bus
);

  calc_state_e          state_q;
  logic                 op_req_q;
  logic                 busy_q;
  logic                 err_q;
  logic [OPERAND_W-1:0] result_q;
  logic [OPERAND_W-1:0] disp_q;
  logic [OPERAND_W-1:0] op_a;
  logic [OPERAND_W-1:0] op_b;

  logic k_digit, k_add, k_eq, k_clr;
  logic ack, clr_now, sum_bad;
  logic a_clr, a_load, a_dig, b_clr, b_dig;

`ifdef CALC_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  assign k_digit = bus.key_pulse && is_digit(bus.key_code);
  assign k_add   = bus.key_pulse && (bus.key_code == KEY_ADD);
  assign k_eq    = bus.key_pulse && (bus.key_code == KEY_EQUALS);
  assign k_clr   = bus.key_pulse && (bus.key_code == KEY_CLEAR);
  assign ack     = (state_q == ST_REQ) && bus.op_ack;
  // an ack in REQ swallows any coincident key, CLEAR included
  assign clr_now = k_clr && !ack;
  assign sum_bad = bus.ovf_in || (bus.sum_in > SUM_W'(OPERAND_MAX));

  always_comb begin
    a_clr  = 1'b0;
    a_load = 1'b0;
    a_dig  = 1'b0;
    b_clr  = 1'b0;
    b_dig  = 1'b0;
    if (clr_now) begin
      a_clr = 1'b1;
      b_clr = 1'b1;
    end else begin
      case (state_q)
        ST_ENT_A: begin
          a_dig = k_digit;
          b_clr = k_add;
        end
        ST_ENT_B: b_dig = k_digit;
        ST_SHOW: begin
          a_clr  = k_digit;
          a_dig  = k_digit;
          a_load = k_add;
          b_clr  = k_digit || k_add;
        end
        default: ;
      endcase
    end
  end

  module_digit_acc #(.MAX_DIGITS(MAX_DIGITS)) u_acc_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (a_clr),
    .load     (a_load),
    .digit_en (a_dig),
    .digit    (bus.key_code),
    .load_val (result_q),
    .value    (op_a)
  );

  module_digit_acc #(.MAX_DIGITS(MAX_DIGITS)) u_acc_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (b_clr),
    .load     (1'b0),
    .digit_en (b_dig),
    .digit    (bus.key_code),
    .load_val ('0),
    .value    (op_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ENT_A;
      op_req_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      disp_q   <= '0;
`ifdef CALC_CTRL_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_ENT_A:         disp_q <= op_a;
        ST_ENT_B, ST_REQ: disp_q <= op_b;
        ST_SHOW:          disp_q <= result_q;
        default:          disp_q <= '0;
      endcase

      if (clr_now) begin
        state_q  <= ST_ENT_A;
        op_req_q <= 1'b0;
        busy_q   <= 1'b0;
        err_q    <= 1'b0;
        result_q <= '0;
      end else begin
        case (state_q)
          ST_ENT_A: if (k_add) state_q <= ST_ENT_B;
          ST_ENT_B: begin
            if (k_eq) begin
              state_q  <= ST_REQ;
              op_req_q <= 1'b1;
              busy_q   <= 1'b1;
`ifdef CALC_CTRL_TIMEOUT_EN
              tmo_q    <= '0;
`endif
            end
          end
          ST_REQ: begin
            if (ack) begin
              op_req_q <= 1'b0;
              busy_q   <= 1'b0;
              if (sum_bad) begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
                // blank the display together with err rather than a cycle later
                disp_q  <= '0;
              end else begin
                result_q <= bus.sum_in[OPERAND_W-1:0];
                state_q  <= ST_SHOW;
              end
            end
`ifdef CALC_CTRL_TIMEOUT_EN
            else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
              op_req_q <= 1'b0;
              busy_q   <= 1'b0;
              state_q  <= ST_ERR;
              err_q    <= 1'b1;
              disp_q   <= '0;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
`endif
          end
          ST_SHOW: begin
            if (k_digit)    state_q <= ST_ENT_A;
            else if (k_add) state_q <= ST_ENT_B;
          end
          ST_ERR: ;
          default: state_q <= ST_ENT_A;
        endcase
      end
    end
  end

  assign bus.op_a     = op_a;
  assign bus.op_b     = op_b;
  assign bus.op_req   = op_req_q;
  assign bus.disp_bin = disp_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_module_calc_ctrl.sv
// Self-checking bench for module_calc_ctrl: vector table, directed corner
// sequences and random key/ack traffic against a behavioural model.
module tb_module_calc_ctrl;
  import calc_pkg::*;

  localparam int MAXD = 3;
  localparam int TMO  = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  module_calc_ctrl_if bus ();

  module_calc_ctrl #(.MAX_DIGITS(MAXD), .ACK_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // behavioural model: phase of the calculation plus decimal operands
  typedef enum int {M_ENTA, M_ENTB, M_WAIT, M_SHOW, M_ERR} mphase_e;
  mphase_e ms;
  int ma, mb, mres, mna, mnb;

  function automatic void m_reset();
    ms = M_ENTA; ma = 0; mb = 0; mres = 0; mna = 0; mnb = 0;
  endfunction

  function automatic void m_key(input int k);
    if (k == 12) begin
      m_reset();
      return;
    end
    case (ms)
      M_ENTA: begin
        if (k <= 9) begin
          if (mna < MAXD) begin ma = ma * 10 + k; mna++; end
        end else if (k == 10) begin
          ms = M_ENTB; mb = 0; mnb = 0;
        end
      end
      M_ENTB: begin
        if (k <= 9) begin
          if (mnb < MAXD) begin mb = mb * 10 + k; mnb++; end
        end else if (k == 11) begin
          ms = M_WAIT;
        end
      end
      M_SHOW: begin
        if (k <= 9) begin
          ma = k; mna = 1; mb = 0; mnb = 0; ms = M_ENTA;
        end else if (k == 10) begin
          ma = mres; mna = MAXD; mb = 0; mnb = 0; ms = M_ENTB;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic void m_ack(input int s, input logic o);
    if (o || s > 4095) ms = M_ERR;
    else begin mres = s; ms = M_SHOW; end
  endfunction

  function automatic int m_disp();
    case (ms)
      M_ENTA:         return ma;
      M_ENTB, M_WAIT: return mb;
      M_SHOW:         return mres;
      default:        return 0;
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".op_a"},     32'(bus.op_a),     32'(ma));
    chk({tag, ".op_b"},     32'(bus.op_b),     32'(mb));
    chk({tag, ".op_req"},   32'(bus.op_req),   32'(ms == M_WAIT));
    chk({tag, ".busy"},     32'(bus.busy),     32'(ms == M_WAIT));
    chk({tag, ".err"},      32'(bus.err),      32'(ms == M_ERR));
    chk({tag, ".disp_bin"}, 32'(bus.disp_bin), 32'(m_disp()));
  endtask

  task automatic press(input int k);
    @(negedge clk);
    bus.key_code  = 4'(k);
    bus.key_pulse = 1'b1;
    @(negedge clk);
    bus.key_pulse = 1'b0;
    bus.key_code  = '0;
  endtask

  task automatic step(input int k, input string tag);
    press(k);
    m_key(k);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic ack(input int s, input logic o);
    @(negedge clk);
    bus.op_ack = 1'b1;
    bus.sum_in = 14'(s);
    bus.ovf_in = o;
    @(negedge clk);
    bus.op_ack = 1'b0;
    bus.ovf_in = 1'b0;
  endtask

  typedef struct {
    int key;
    int ea;
    int eb;
    int ed;
  } vec_t;
  vec_t tbl [17];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int n;
    int acked;
    int r, s, k;
    logic o;

    tbl = '{
      '{1, 1, 0, 1},       '{2, 12, 0, 12},     '{3, 123, 0, 123},
      '{4, 123, 0, 123},   '{11, 123, 0, 123},  '{14, 123, 0, 123},
      '{10, 123, 0, 0},    '{0, 123, 0, 0},     '{0, 123, 0, 0},
      '{7, 123, 7, 7},     '{8, 123, 7, 7},     '{10, 123, 7, 7},
      '{12, 0, 0, 0},      '{9, 9, 0, 9},       '{9, 99, 0, 99},
      '{9, 999, 0, 999},   '{9, 999, 0, 999}
    };

    bus.key_code = '0; bus.key_pulse = 1'b0; bus.op_ack = 1'b0;
    bus.sum_in = '0; bus.ovf_in = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    m_reset();
    check_all("reset");
    rst_n = 1'b1;

    // entry rules: digit limit, leading zeros, ignored keys, clear
    foreach (tbl[i]) begin
      press(tbl[i].key);
      m_key(tbl[i].key);
      @(negedge clk);
      chk($sformatf("tbl%0d.op_a", i), 32'(bus.op_a), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d.op_b", i), 32'(bus.op_b), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d.disp", i), 32'(bus.disp_bin), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d.err", i), 32'(bus.err), 32'd0);
      chk($sformatf("tbl%0d.busy", i), 32'(bus.busy), 32'd0);
    end

    // 123 + 45, ack in the third request cycle
    step(12, "s36");
    foreach (tbl[i]) if (i < 0) ; // keep tbl in scope only
    step(1, "s36"); step(2, "s36"); step(3, "s36"); step(10, "s36");
    step(4, "s36"); step(5, "s36");
    press(11); m_key(11);
    n = 0; acked = 0;
    for (int c = 0; c < 20 && !(acked != 0 && !bus.op_req); c++) begin
      if (bus.op_req) n++;
      if (n == 3 && acked == 0) begin
        chk("s36.hold_a", 32'(bus.op_a), 32'd123);
        chk("s36.hold_b", 32'(bus.op_b), 32'd45);
        bus.op_ack = 1'b1; bus.sum_in = 14'd168; acked = 1;
      end
      @(negedge clk);
      bus.op_ack = 1'b0;
    end
    chk("s36.req_cycles", 32'(n), 32'd3);
    m_ack(168, 1'b0);
    @(negedge clk);
    check_all("s36.show");
    chk("s36.disp168", 32'(bus.disp_bin), 32'd168);

    // chaining the shown result into a new addition
    step(10, "s40"); step(2, "s40");
    press(11); m_key(11);
    ack(170, 1'b0); m_ack(170, 1'b0);
    @(negedge clk);
    check_all("s40");
    chk("s40.op_a", 32'(bus.op_a), 32'd168);
    chk("s40.disp170", 32'(bus.disp_bin), 32'd170);

    // adder overflow flag, then recovery
    step(12, "s38"); step(5, "s38"); step(10, "s38"); step(5, "s38"); step(11, "s38");
    ack(10, 1'b1); m_ack(10, 1'b1);
    @(negedge clk);
    check_all("s38.err");
    chk("s38.err_hi", 32'(bus.err), 32'd1);
    step(12, "s38.clr");

    // sum above 4095 without ovf, keys ignored while in error
    step(1, "big"); step(10, "big"); step(1, "big"); step(11, "big");
    ack(4096, 1'b0); m_ack(4096, 1'b0);
    @(negedge clk);
    check_all("big.err");
    step(5, "err.dig"); step(10, "err.add"); step(11, "err.eq");
    step(12, "err.clr");

    // ack outside a request has no effect
    @(negedge clk); bus.op_ack = 1'b1; bus.sum_in = 14'd77;
    @(negedge clk); bus.op_ack = 1'b0;
    @(negedge clk);
    check_all("stray_ack");

    // request without ack
    step(1, "tmo"); step(10, "tmo"); step(2, "tmo");
    press(11); m_key(11);
    n = 0;
    for (int c = 0; c < 400 && bus.op_req; c++) begin
      n++;
      @(negedge clk);
    end
`ifdef CALC_CTRL_TIMEOUT_EN
    chk("tmo.req_cycles", 32'(n), 32'(TMO));
    chk("tmo.err", 32'(bus.err), 32'd1);
    ms = M_ERR;
    @(negedge clk);
    check_all("tmo.after");
`else
    chk("tmo.req_cycles", 32'(n), 32'd400);
`endif
    step(12, "tmo.clr");

    // asynchronous reset in the middle of a request
    step(7, "arst"); step(10, "arst"); step(8, "arst");
    press(11); m_key(11);
    chk("arst.req_before", 32'(bus.op_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_all("arst.now");
    @(negedge clk);
    rst_n = 1'b1;
    step(3, "arst.after");

    // CLEAR coincident with ack: ack wins
    step(10, "ackclr"); step(1, "ackclr");
    press(11); m_key(11);
    @(negedge clk);
    bus.op_ack = 1'b1; bus.sum_in = 14'd4; bus.key_code = 4'hC; bus.key_pulse = 1'b1;
    @(negedge clk);
    bus.op_ack = 1'b0; bus.key_pulse = 1'b0; bus.key_code = '0;
    m_ack(4, 1'b0);
    @(negedge clk);
    check_all("ackclr");
    chk("ackclr.disp", 32'(bus.disp_bin), 32'd4);

    // random traffic against the model
    for (int it = 0; it < 300; it++) begin
      if (ms == M_WAIT) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        r = int'($urandom_range(0, 9));
        if (r == 0) begin
          press(12); m_key(12);
        end else begin
          s = (r == 1) ? int'($urandom_range(0, 16383)) : ma + mb;
          o = (r == 2);
          ack(s, o); m_ack(s, o);
        end
      end else begin
        if ($urandom_range(0, 3) == 0) k = int'($urandom_range(10, 15));
        else                           k = int'($urandom_range(0, 9));
        press(k); m_key(k);
      end
      @(negedge clk);
      check_all($sformatf("rand%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/module_calc_ctrl.md
MODULE_CALC_CTRL -- requirements
Module: module_calc_ctrl

Interface
REQ-001 Parameter MAX_DIGITS, default 3: maximum decimal digits accepted per operand.
REQ-002 Parameter ACK_TIMEOUT, default 255: cycles op_req may stay high without op_ack before error.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 key_code  input  4  keypad code, valid while key_pulse high.
REQ-006 key_pulse  input  1  one-cycle strobe per accepted keypress.
REQ-007 op_a  output  12  operand A, binary.
REQ-008 op_b  output  12  operand B, binary.
REQ-009 op_req  output  1  add request to adder datapath.
REQ-010 op_ack  input  1  adder result valid; completes handshake.
REQ-011 sum_in  input  14  adder result, binary.
REQ-012 ovf_in  input  1  adder overflow flag, sampled with op_ack.
REQ-013 disp_bin  output  12  binary value for the BCD/display path.
REQ-014 err  output  1  error indication; disp_bin forced to 0 while high.
REQ-015 busy  output  1  high while in REQ.

Function
REQ-016 Key map: 0x0-0x9 digit, 0xA ADD, 0xB EQUALS, 0xC CLEAR, 0xD-0xF ignored.
REQ-017 States: ENT_A, ENT_B, REQ, SHOW, ERR; key_pulse is consumed only in the cycle it is high.
REQ-018 Digit in ENT_A/ENT_B: operand <= operand*10 + digit if operand's digit count < MAX_DIGITS, else ignored; leading zeros count as digits.
REQ-019 ENT_A: ADD -> ENT_B with op_b=0; EQUALS ignored.
REQ-020 ENT_B: EQUALS -> REQ; ADD ignored.
REQ-021 REQ: op_req high starting the cycle after EQUALS; op_a/op_b held stable until op_ack sampled high.
REQ-022 op_ack in REQ: if ovf_in=1 or sum_in>4095 -> ERR, else result <= sum_in[11:0] and -> SHOW; op_req low next cycle.
REQ-023 op_ack outside REQ is ignored.
REQ-024 SHOW: digit -> ENT_A with op_a=digit and op_b=0; ADD -> ENT_B with op_a=result (chaining); EQUALS ignored.
REQ-025 ERR: only CLEAR leaves; all other keys ignored.
REQ-026 CLEAR in any state -> ENT_A with op_a=op_b=result=0 and err=0; in REQ it aborts the request, op_req low next cycle.
REQ-027 Simultaneous op_ack and key_pulse in REQ: ack processed and key discarded, including CLEAR.
REQ-028 disp_bin registered: ENT_A->op_a, ENT_B->op_b, REQ->op_b, SHOW->result, ERR->0; it updates one cycle after the state change.
REQ-029 err=1 exactly while in ERR; busy=1 exactly while in REQ.

Reset
REQ-030 rst_n low: state ENT_A, op_a=op_b=result=0, digit counters 0, op_req=0, disp_bin=0, err=0, busy=0, timeout counter 0.
REQ-031 Reset assertion mid-handshake drops op_req asynchronously; no pending request survives reset.

Configuration
REQ-032 Macro CALC_CTRL_TIMEOUT_EN defined: counter runs in REQ; reaching ACK_TIMEOUT cycles without op_ack -> ERR with op_req low next cycle.
REQ-033 Macro CALC_CTRL_TIMEOUT_EN undefined: no counter is synthesized and REQ waits indefinitely for op_ack or CLEAR.

Structure
REQ-034 Shared package calc_pkg: key code constants, state enum typedef, OPERAND_W=12, SUM_W=14.
REQ-035 One sub-module module_digit_acc: x10+digit accumulator with digit counter, clear and load ports, instantiated for op_a and op_b.

Verification
REQ-036 Keys 1,2,3,A,4,5,= with ack after 3 cycles and sum_in=168 -> op_a=123, op_b=45, op_req high 3 cycles, disp_bin=168, err=0.
REQ-037 Keys 9,9,9,9 -> op_a=999 and the fourth digit is ignored; disp_bin=999.
REQ-038 Keys 5,A,5,= then ack with ovf_in=1 -> err=1, disp_bin=0; C -> err=0, ENT_A, disp_bin=0.
REQ-039 With CALC_CTRL_TIMEOUT_EN and no ack -> op_req high exactly 255 cycles, then err=1; without the macro -> op_req stays high until C.
REQ-040 Result 168 in SHOW, keys A,2,= with sum_in=170 -> op_a=168, op_b=2, disp_bin=170.
REQ-041 rst_n low while op_req=1 -> op_req=0 immediately and all outputs at REQ-030 values; key C coincident with op_ack -> result shown and C ignored.
